// File: rtl/jtag_master.sv
// JTAG master: shifts 1..64 TMS or TDI bits per command at a fixed TCK rate
// and returns the captured TDO bits through a valid/ready response.
module jtag_master #(
    parameter int CLK_DIV = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_mode_i,
    input  logic [5:0]  cmd_len_i,
    input  logic [63:0] cmd_data_i,
    input  logic        cmd_tms_last_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

    state_t      r_state;
    logic [7:0]  r_phase;
    logic [6:0]  r_bit;
    logic        r_mode;
    logic [5:0]  r_len;
    logic [63:0] r_data;
    logic        r_tms_last;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [63:0] r_rsp;

    logic        w_phase_done;
    logic        w_last;
    logic [5:0]  w_nidx;
    logic        w_nxt_tms;
    logic        w_nxt_tdi;
    logic        w_c0_tms;
    logic        w_c0_tdi;

    assign w_phase_done = (r_phase == 8'(CLK_DIV - 1));
    assign w_last       = (r_bit == {1'b0, r_len});
    assign w_nidx       = r_bit[5:0] + 6'd1;

    // TMS only follows data in TMS mode; in shift mode it rises on the last bit
    assign w_nxt_tms = r_mode ? ((w_nidx == r_len) & r_tms_last)
                              : r_data[w_nidx];
    assign w_nxt_tdi = r_mode & r_data[w_nidx];
    assign w_c0_tms  = cmd_mode_i ? ((cmd_len_i == 6'd0) & cmd_tms_last_i)
                                  : cmd_data_i[0];
    assign w_c0_tdi  = cmd_mode_i & cmd_data_i[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_phase     <= 8'd0;
            r_bit       <= 7'd0;
            r_mode      <= 1'b0;
            r_len       <= 6'd0;
            r_data      <= 64'd0;
            r_tms_last  <= 1'b0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp       <= 64'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_mode      <= cmd_mode_i;
                        r_len       <= cmd_len_i;
                        r_data      <= cmd_data_i;
                        r_tms_last  <= cmd_tms_last_i;
                        r_tms       <= w_c0_tms;
                        r_tdi       <= w_c0_tdi;
                        r_rsp       <= 64'd0;
                        r_phase     <= 8'd0;
                        r_bit       <= 7'd0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= LOW;
                    end
                end
                LOW: begin
                    if (w_phase_done) begin
                        r_phase <= 8'd0;
                        r_tck   <= 1'b1;
                        r_state <= HIGH;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                HIGH: begin
                    if (w_phase_done) begin
                        r_phase            <= 8'd0;
                        r_tck              <= 1'b0;
                        r_rsp[r_bit[5:0]] <= tdo_i;
                        if (w_last) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_bit   <= r_bit + 7'd1;
                            r_tms   <= w_nxt_tms;
                            r_tdi   <= w_nxt_tdi;
                            r_state <= LOW;
                        end
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp;
    assign tck_o       = r_tck;
    assign tms_o       = r_tms;
    assign tdi_o       = r_tdi;

endmodule
